// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared width, state and mode definitions for the add/sub family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam int ADDSUB_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : addsub_pkg

`default_nettype wire

// File: rtl/addsub_operand_recover_serial_fa_bit.sv
// ============================================================================
// Module      : serial_fa_bit
// Description : Combinational 1-bit full adder used as the serial datapath slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : serial_fa_bit

`default_nettype wire

// File: rtl/addsub_operand_recover.sv
// ============================================================================
// Module      : addsub_operand_recover
// Description : Bit-serial recovery of operand A from answer, b and mode s.
//               Optional operand compare enabled by ADDSUB_OPERAND_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_operand_recover
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] answer,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic             wrap
`ifdef ADDSUB_OPERAND_CHECK_EN
  ,
  input  logic [WIDTH-1:0] a_expected,
  output logic             mismatch
`endif
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] ans_sr_q, ans_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] a_out_q,  a_out_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             mode_q,   mode_d;
  logic             carry_q,  carry_d;
  logic             wrap_q,   wrap_d;

  logic             bx;
  logic             sum_bit;
  logic             cout_bit;
  logic [WIDTH-1:0] result_final;

  // Subtraction is answer + ~b + 1, hence the inverted b and carry-in of ~s.
  assign bx           = b_sr_q[0] ^ ~mode_q;
  assign result_final = {sum_bit, res_sr_q[WIDTH-1:1]};

  serial_fa_bit u_fa (
    .a_i    (ans_sr_q[0]),
    .b_i    (bx),
    .cin_i  (carry_q),
    .sum_o  (sum_bit),
    .cout_o (cout_bit)
  );

`ifdef ADDSUB_OPERAND_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d  = state_q;
    ans_sr_d = ans_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    a_out_d  = a_out_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    wrap_d   = wrap_q;
`ifdef ADDSUB_OPERAND_CHECK_EN
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          ans_sr_d = answer;
          b_sr_d   = b;
          res_sr_d = '0;
          mode_d   = s;
          carry_d  = ~s;
          cnt_d    = '0;
`ifdef ADDSUB_OPERAND_CHECK_EN
          exp_d    = a_expected;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        ans_sr_d = ans_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = result_final;
        carry_d  = cout_bit;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          a_out_d = result_final;
          // For subtract the carry is an inverted borrow.
          wrap_d  = (mode_q == MODE_SUB) ? cout_bit : ~cout_bit;
`ifdef ADDSUB_OPERAND_CHECK_EN
          mismatch_d = (result_final != exp_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ans_sr_q <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      a_out_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ans_sr_q <= ans_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      a_out_q  <= a_out_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef ADDSUB_OPERAND_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign a_out = a_out_q;
  assign wrap  = wrap_q;

endmodule : addsub_operand_recover

`default_nettype wire

// File: tb/tb_addsub_operand_recover.sv
// ============================================================================
// Module      : tb_addsub_operand_recover
// Description : Directed self-checking bench for addsub_operand_recover.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_operand_recover;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] answer;
  logic [W-1:0] b;
  logic         s;
  logic         busy;
  logic         done;
  logic [W-1:0] a_out;
  logic         wrap;
`ifdef ADDSUB_OPERAND_CHECK_EN
  logic [W-1:0] a_expected;
  logic         mismatch;
`endif

  int checks = 0;
  int fails  = 0;
  int cycles;
  int late_done;

  always #5 clk = ~clk;

  addsub_operand_recover #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .answer     (answer),
    .b          (b),
    .s          (s),
    .busy       (busy),
    .done       (done),
    .a_out      (a_out),
    .wrap       (wrap)
`ifdef ADDSUB_OPERAND_CHECK_EN
    ,
    .a_expected (a_expected),
    .mismatch   (mismatch)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one op at a negedge; returns at the negedge after edge 0.
  task automatic launch(input logic [W-1:0] ans, input logic [W-1:0] bb, input logic ss);
    answer = ans;
    b      = bb;
    s      = ss;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts busy cycles (bounded) and stops in the cycle after the last RUN edge.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ans, input logic [W-1:0] bb,
                        input logic ss, input logic [W-1:0] ea, input logic ew);
    int n;
    launch(ans, bb, ss);
    wait_busy(n);
    chk({tag, " busy_cycles"}, n, 6);
    chk({tag, " done"}, done, 1);
    chk({tag, " a_out"}, a_out, ea);
    chk({tag, " wrap"}, wrap, ew);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    answer = '0;
    b      = '0;
    s      = 1'b0;
`ifdef ADDSUB_OPERAND_CHECK_EN
    a_expected = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst a_out", a_out, 0);
    chk("rst wrap", wrap, 0);
`ifdef ADDSUB_OPERAND_CHECK_EN
    chk("rst mismatch", mismatch, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sub48_33", 6'd48, 6'd33, 1'b0, 6'd15, 1'b0);
    run_op("sub5_10",  6'd5,  6'd10, 1'b0, 6'd59, 1'b1);
    run_op("add40_33", 6'd40, 6'd33, 1'b1, 6'd9,  1'b1);
    run_op("add18_33", 6'd18, 6'd33, 1'b1, 6'd51, 1'b0);

    // Back-to-back: start held through DONE, second op captured at the DONE edge.
    answer = 6'd48; b = 6'd33; s = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("b2b busy1", busy, 1);
    chk("b2b a_out_hold", a_out, 51);
    wait_busy(cycles);
    chk("b2b first cycles", cycles, 6);
    chk("b2b first done", done, 1);
    chk("b2b first a_out", a_out, 15);
    answer = 6'd40; b = 6'd33; s = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b no_idle", busy, 1);
    wait_busy(cycles);
    chk("b2b second cycles", cycles, 6);
    chk("b2b second a_out", a_out, 9);
    chk("b2b second wrap", wrap, 1);
    @(negedge clk);

    // Start pulse and input changes mid-RUN are ignored.
    launch(6'd5, 6'd10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; answer = 6'd18; b = 6'd33; s = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun a_out_hold", a_out, 9);
    cycles = 3;
    while (busy && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    chk("midrun cycles", cycles, 6);
    chk("midrun a_out", a_out, 59);
    chk("midrun wrap", wrap, 1);
    @(negedge clk);
    chk("midrun no_restart", busy, 0);

    // Reset at the 3rd RUN cycle aborts the op.
    launch(6'd40, 6'd33, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort a_out", a_out, 0);
    chk("abort wrap", wrap, 0);
    rst_n = 1'b1;
    late_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) late_done++;
    end
    chk("abort late_done", late_done, 0);

`ifdef ADDSUB_OPERAND_CHECK_EN
    a_expected = 6'd14;
    run_op("chk_miss", 6'd48, 6'd33, 1'b0, 6'd15, 1'b0);
    chk("chk mismatch1", mismatch, 1);
    a_expected = 6'd15;
    run_op("chk_hit", 6'd48, 6'd33, 1'b0, 6'd15, 1'b0);
    chk("chk mismatch0", mismatch, 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_addsub_operand_recover

`default_nettype wire
